// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter.
// Sends a latched MSB-first frame on x_out, one bit every bit_div+1 clocks.
// Frames can be repeated, with a one-bit-period idle gap between them.
module seq_pattern_tx #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned DIV_W   = 8,
  localparam int unsigned LW     = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  input  logic [3:0]         repeat_cnt,
  input  logic [DIV_W-1:0]   bit_div,
  output logic               x_out,
  output logic               x_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic [3:0]         frm_q, frm_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [DIV_W-1:0]   bdiv_q, bdiv_d;
  logic               x_q, x_d;
  logic               xv_q, xv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               len_ok;
  logic               wrap;
  logic [MAX_LEN-1:0] pat_sh;

  // Next-state, counter and output decode; everything holds while ena is low.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    pat_d   = pat_q;
    len_d   = len_q;
    bdiv_d  = bdiv_q;

    len_ok  = (len != '0) && (len <= LW'(MAX_LEN));
    wrap    = (div_q == bdiv_q);

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort && len_ok) begin
          state_d = S_SEND;
          pat_d   = pattern;
          len_d   = len;
          frm_d   = repeat_cnt;
          bdiv_d  = bit_div;
          div_d   = '0;
          idx_d   = len - LW'(1);
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
          div_d   = '0;
          idx_d   = '0;
          frm_d   = '0;
        end else if (wrap) begin
          div_d = '0;
          if (idx_q == '0) begin
            state_d = (frm_q != '0) ? S_GAP : S_DONE;
          end else begin
            idx_d = idx_q - LW'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          div_d   = '0;
          idx_d   = '0;
          frm_d   = '0;
        end else if (wrap) begin
          state_d = S_SEND;
          div_d   = '0;
          idx_d   = len_q - LW'(1);
          frm_d   = frm_q - 4'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered outputs
    // line up with the state they describe, without any input-to-output path.
    pat_sh = pat_d >> idx_d;
    x_d    = (state_d == S_SEND) && pat_sh[0];
    xv_d   = (state_d == S_SEND);
    busy_d = (state_d == S_SEND) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      bdiv_q  <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      bdiv_q  <= bdiv_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x_out   = x_q;
  assign x_valid = xv_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: directed scenarios plus randomized traffic,
// checked cycle by cycle against a waveform-queue reference model.
module tb_seq_pattern_tx;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned DIV_W   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] repeat_cnt = '0;
  logic [7:0] bit_div = '0;
  logic       x_out, x_valid, busy, done;

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .len        (len),
    .repeat_cnt (repeat_cnt),
    .bit_div    (bit_div),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected outputs for the rest of a burst, one entry per
  // enabled clock, built directly from the frame/gap/done description.
  typedef struct packed {
    logic x;
    logic v;
    logic b;
    logic d;
  } out_t;

  out_t q[$];
  out_t cur = '0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void build(input logic [7:0] p, input int l, input int r, input int bd);
    logic [7:0] sh;
    out_t e;
    for (int f = 0; f <= r; f++) begin
      for (int i = l - 1; i >= 0; i--) begin
        sh = p >> i;
        e  = '{x: sh[0], v: 1'b1, b: 1'b1, d: 1'b0};
        for (int k = 0; k <= bd; k++) q.push_back(e);
      end
      if (f < r) begin
        e = '{x: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0};
        for (int k = 0; k <= bd; k++) q.push_back(e);
      end
    end
    q.push_back('{x: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1});
  endfunction

  function automatic void model_edge();
    if (rst) begin
      q.delete();
      cur = '0;
    end else if (ena) begin
      if (cur.d) begin
        cur = '0;
      end else if (q.size() == 0) begin
        if (start && !abort && len >= 1 && len <= MAX_LEN) begin
          build(pattern, int'(len), int'(repeat_cnt), int'(bit_div));
          cur = q.pop_front();
        end
      end else if (abort) begin
        q.delete();
        cur = '0;
      end else begin
        cur = q.pop_front();
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("x_out", 32'(x_out), 32'(cur.x));
    check("x_valid", 32'(x_valid), 32'(cur.v));
    check("busy", 32'(busy), 32'(cur.b));
    check("done", 32'(done), 32'(cur.d));
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic burst(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                       input logic [7:0] bd, input int n);
    pattern = p; len = l; repeat_cnt = r; bit_div = bd;
    ena = 1'b1; abort = 1'b0; start = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    tick();
    start = 1'b0;
    repeat (n) tick();
  endtask

  function automatic int burst_len(input int l, input int r, input int bd);
    return (r + 1) * l * (bd + 1) + r * (bd + 1);
  endfunction

  initial begin
    // Reset state
    #2;
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_x_valid", 32'(x_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) tick();
    rst = 1'b0; ena = 1'b1;
    repeat (2) tick();

    // Single frame, no divide
    burst(8'b100, 4'd3, 4'd0, 8'd0, 6);
    check("t1_busy_len", busy_cnt, burst_len(3, 0, 0));
    check("t1_done_cnt", done_cnt, 1);

    // Bit divider
    burst(8'b100, 4'd3, 4'd0, 8'd2, 12);
    check("t2_busy_len", busy_cnt, burst_len(3, 0, 2));
    check("t2_done_cnt", done_cnt, 1);

    // Repeat frames: 100,gap,100,gap,100 -> 11 busy clocks
    burst(8'b100, 4'd3, 4'd2, 8'd0, 14);
    check("t3_busy_len", busy_cnt, 11);
    check("t3_done_cnt", done_cnt, 1);

    // Abort on the 2nd bit
    burst(8'b100, 4'd3, 4'd0, 8'd0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);

    // start while busy is ignored; configuration changes do not disturb the burst
    burst(8'b1011, 4'd4, 4'd1, 8'd1, 3);
    pattern = 8'hFF; len = 4'd2; bit_div = 8'd0; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    repeat (20) tick();
    check("midstart_busy_len", busy_cnt, burst_len(4, 1, 1));
    check("midstart_done_cnt", done_cnt, 1);

    // Invalid lengths and abort+start in IDLE
    burst(8'hA5, 4'd0, 4'd0, 8'd0, 4);
    check("len0_busy", busy_cnt, 0);
    burst(8'hA5, 4'd9, 4'd0, 8'd0, 4);
    check("len9_busy", busy_cnt, 0);
    abort = 1'b1; start = 1'b1; len = 4'd3; busy_cnt = 0;
    tick();
    abort = 1'b0; start = 1'b0;
    repeat (3) tick();
    check("abort_start_busy", busy_cnt, 0);

    // Enable freeze for 5 clocks during bit 1
    burst(8'b100, 4'd3, 4'd0, 8'd3, 1);
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    repeat (20) tick();
    check("freeze_busy_len", busy_cnt, burst_len(3, 0, 3) + 5);
    check("freeze_done_cnt", done_cnt, 1);

    // Asynchronous reset during GAP
    burst(8'b100, 4'd3, 4'd1, 8'd1, 0);
    for (int i = 0; i < 40 && !(cur.b && !cur.v); i++) tick();
    check("reached_gap", 32'(cur.b && !cur.v), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_x_out", 32'(x_out), 32'd0);
    check("arst_x_valid", 32'(x_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    repeat (3) tick();
    check("arst_no_done", done_cnt, 0);
    burst(8'b100, 4'd3, 4'd1, 8'd1, 20);
    check("post_rst_busy_len", busy_cnt, burst_len(3, 1, 1));
    check("post_rst_done_cnt", done_cnt, 1);

    // Boundaries: maximum length and frame count, maximum divider
    burst(8'h5C, 4'd8, 4'd15, 8'd0, 150);
    check("maxfrm_busy_len", busy_cnt, burst_len(8, 15, 0));
    check("maxfrm_done_cnt", done_cnt, 1);
    burst(8'h01, 4'd1, 4'd0, 8'd255, 260);
    check("maxdiv_busy_len", busy_cnt, 256);
    check("maxdiv_done_cnt", done_cnt, 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      ena        = ($urandom_range(0, 9) != 0);
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      pattern    = 8'($urandom);
      len        = 4'($urandom_range(0, 10));
      repeat_cnt = 4'($urandom_range(0, 3));
      bit_div    = 8'($urandom_range(0, 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter. It drives a programmable bit sequence, for example `100`, onto a single serial line `x_out` at a programmable bit rate, with optional frame repeats. It is the stimulus/transmit end for the on-chip sequence detector and sits between the `ui_in`/`uio_in` configuration pins and the detector's serial input `x`. Status outputs report when a burst is in progress and when it completes.

## Interface
- `MAX_LEN`, default 8: pattern register width and maximum frame length in bits.
- `DIV_W`, default 8: bit-period divider width.
- `clk`  in  1  the single clock domain; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  global enable; when low, all state, counters and outputs hold.
- `start`  in  1  request a burst; sampled only in IDLE with `ena`=1.
- `abort`  in  1  cancel the current burst; sampled with `ena`=1.
- `pattern`  in  MAX_LEN  frame bits; bit `len-1` is sent first (MSB-first).
- `len`  in  $clog2(MAX_LEN+1)  frame length in bits. Valid range is 1..MAX_LEN; 0 is not a valid length.
- `repeat_cnt`  in  4  extra frames to send: 0 means one frame, N means N+1 frames.
- `bit_div`  in  DIV_W  each bit is held for `bit_div+1` clocks.
- `x_out`  out  1  serial data; 0 whenever not sending.
- `x_valid`  out  1  high while `x_out` carries a pattern bit.
- `busy`  out  1  high in SEND and GAP states.
- `done`  out  1  one-cycle pulse when a burst ends normally.

## Operation
- States are IDLE, SEND, GAP and DONE. Reset enters IDLE.
- **Reset values:** `x_out`=0, `x_valid`=0, `busy`=0, `done`=0; all internal counters are 0.
- **IDLE to SEND:** taken when `ena`=1, `start`=1, `abort`=0, and `len` is in 1..MAX_LEN.
  - On that edge, `pattern`, `len`, `repeat_cnt` and `bit_div` are latched.
  - Latched values are not affected by later input changes until the next accepted start.
- **Invalid length:** `start` with `len`=0 or `len`>MAX_LEN is ignored. The block stays in IDLE and `done` is not pulsed.
- **SEND:**
  - Bit index starts at `len-1` and decrements.
  - The divider counts 0..`bit_div`; the bit index advances when the divider wraps.
  - `x_out` = latched `pattern[index]` and `x_valid`=1.
- **End of frame:** when index 0 completes its bit period:
  - If frames remain, go to GAP.
  - Otherwise go to DONE.
- **GAP:**
  - Lasts one bit period (`bit_div+1` clocks) with `x_out`=0 and `x_valid`=0. This lets the detector's idle level separate frames.
  - Then return to SEND with index reloaded to `len-1` and the remaining-frame count decremented.
- **DONE:** lasts exactly one clock with `done`=1 and `busy`=0, then goes to IDLE.
- **`start` while busy:** ignored. It is neither queued nor counted.
- **`abort`:** with `ena`=1 in SEND or GAP, the next state is IDLE.
  - Outputs go to their reset values on that edge.
  - `done` is not pulsed.
  - `abort` and `start` asserted together in IDLE: `abort` wins and nothing starts.
- **`ena`=0:** freezes the state, divider, index and frame count. Outputs hold their current values, including a `done` that is already high. Operation resumes exactly where it stopped.
- **`rst` mid-burst:** immediately returns the block to IDLE with reset outputs. No partial bit and no `done` pulse follow.
- **Width rules:**
  - The divider is DIV_W bits; `bit_div` = 2^DIV_W−1 is legal and gives a 2^DIV_W-clock bit period.
  - The frame counter is 4 bits, so at most 16 frames are sent.

## Timing
- **Start latency:** start accepted at edge k. From edge k+1, `busy`=1, `x_valid`=1 and `x_out` = `pattern[len-1]`.
- **Bit period:** each bit is stable for exactly `bit_div+1` clocks. Transitions occur only on divider wrap.
- **Frame length:** one frame occupies `len*(bit_div+1)` clocks.
- **Total burst length:** with R = `repeat_cnt`, busy lasts (R+1)·`len`·(`bit_div`+1) + R·(`bit_div`+1) clocks.
- **Done position:** `done` is high on the clock immediately after the last bit period. The next `start` can be accepted on the clock after `done`.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Single frame, no divide:** `pattern`=0b100, `len`=3, `bit_div`=0, `repeat_cnt`=0, pulse `start`.
  - `x_out` must be 1,0,0 on the 3 clocks after acceptance, with `x_valid`=1 and `busy`=1.
  - `done` must pulse on the 4th clock; the block is then IDLE.
- **Bit divider:** same pattern with `bit_div`=2. Each bit is held 3 clocks (1,1,1,0,0,0,0,0,0) and `done` pulses at clock 10.
- **Repeat frames:** `repeat_cnt`=2, `bit_div`=0, `len`=3.
  - Expect the sequence 100,gap,100,gap,100, where each gap is one clock of `x_out`=0 with `x_valid`=0.
  - `busy` lasts 11 clocks, and a loopback detector flags the sequence 3 times.
- **Abort and ignored start:**
  - Assert `abort` on the 2nd bit: the block is IDLE next clock, `x_out`=0, and there is no `done`.
  - Pulse `start` mid-burst: no effect on the burst.
  - Pulse `start` with `len`=0: the block stays IDLE.
- **Enable freeze:** drop `ena` for 5 clocks during bit 1 with `bit_div`=3.
  - `x_out` holds its value and the remaining bit period resumes unchanged.
  - Total busy time is extended by exactly 5 clocks.
- **Reset mid-burst:** assert `rst` asynchronously between clock edges during GAP.
  - All outputs go to 0 immediately.
  - After release, a new `start` runs a full, correct burst.
